// File: rtl/regslv_field_mp.sv
// Software/hardware accessible register field with NUM_SW arbitrated ports, onwrite/onread side effects and write-once lock.
// Writes land 1 cycle after the strobe; read data is combinational in the strobe cycle; never stalls (no backpressure).
module regslv_field_mp #(
  parameter int                 F_WIDTH    = 32,
  parameter logic [F_WIDTH-1:0] RST_VALUE  = '0,
  parameter int                 SW_TYPE    = 0,
  parameter int                 ONWRITE    = 0,
  parameter int                 ONREAD     = 0,
  parameter int                 WRITE_ONCE = 0,
  parameter int                 NUM_SW     = 2,
  parameter int                 HW_PRIO    = 0
) (
  input  logic                        fsm_clk,
  input  logic                        fsm_rstn,
  input  logic                        soft_rst,
  input  logic [NUM_SW-1:0]           sw_wr_en,
  input  logic [NUM_SW-1:0]           sw_rd_en,
  input  logic [NUM_SW*F_WIDTH-1:0]   sw_wr_data,
  output logic [F_WIDTH-1:0]          sw_rd_data,
  input  logic                        hw_pulse,
  input  logic [F_WIDTH-1:0]          hw_next_value,
  output logic [F_WIDTH-1:0]          curr_value,
  output logic                        swmod,
  output logic                        swacc,
  output logic                        sw_conflict,
  output logic                        wo_locked
);

  logic [F_WIDTH-1:0] value_q, value_d;
  logic               lock_q, lock_d;

  logic [NUM_SW-1:0]  req;
  logic               gnt_vld;
  logic               gnt_wr;
  logic [F_WIDTH-1:0] gnt_dat;
  logic [F_WIDTH-1:0] wr_res;
  logic [F_WIDTH-1:0] sw_val;
  logic               wr_eff;
  logic               rd_act;
  logic               sw_side;

  // Descending scan so the lowest-index requester is the one left standing.
  always_comb begin
    req     = sw_wr_en | sw_rd_en;
    gnt_vld = 1'b0;
    gnt_wr  = 1'b0;
    gnt_dat = '0;
    for (int i = NUM_SW - 1; i >= 0; i--) begin
      if (req[i]) begin
        gnt_vld = 1'b1;
        gnt_wr  = sw_wr_en[i];
        gnt_dat = sw_wr_data[i*F_WIDTH +: F_WIDTH];
      end
    end
  end

  assign sw_conflict = (req & (req - NUM_SW'(1))) != '0;

  always_comb begin
    case (ONWRITE)
      1:       wr_res = value_q & ~gnt_dat;
      2:       wr_res = value_q | gnt_dat;
      3:       wr_res = value_q ^ gnt_dat;
      4:       wr_res = value_q | ~gnt_dat;
      5:       wr_res = value_q & gnt_dat;
      6:       wr_res = value_q ^ ~gnt_dat;
      7:       wr_res = '0;
      8:       wr_res = '1;
      default: wr_res = gnt_dat;
    endcase
  end

  assign wr_eff  = gnt_vld && gnt_wr && (SW_TYPE != 1) && !((WRITE_ONCE != 0) && lock_q);
  assign rd_act  = gnt_vld && !gnt_wr;
  assign sw_side = wr_eff || (rd_act && (ONREAD != 0));

  always_comb begin
    sw_val  = wr_eff ? wr_res : ((ONREAD == 2) ? '1 : '0);
    value_d = value_q;
    // A blocked (ineffective) write is not a side effect, so HW still updates.
    if (sw_side && (!hw_pulse || (HW_PRIO == 0))) begin
      value_d = sw_val;
    end else if (hw_pulse) begin
      value_d = hw_next_value;
    end
    lock_d = lock_q || (wr_eff && (WRITE_ONCE != 0));
  end

  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      value_q <= RST_VALUE;
      lock_q  <= 1'b0;
    end else if (soft_rst) begin
      value_q <= RST_VALUE;
      lock_q  <= 1'b0;
    end else begin
      value_q <= value_d;
      lock_q  <= lock_d;
    end
  end

  assign sw_rd_data = (rd_act && (SW_TYPE != 2)) ? value_q : '0;
  assign curr_value = value_q;
  assign swmod      = wr_eff;
  assign swacc      = rd_act;
  assign wo_locked  = lock_q;

endmodule

// File: doc/regslv_field_mp.md
Name: regslv_field_mp

Overview:
- Parametrised, multi-port software-accessible register field. It is the next-generation building block instantiated inside regslv register blocks.
- Onwrite behaviours NA/WOCLR/WOSET/WOT/WZS/WZC/WZT are selectable per instance. It adds WCLR/WSET, onread side effects (RCLR/RSET), write-once locking, configurable HW/SW priority and NUM_SW arbitrated software access ports.
- It sits between the regslv address decoder (per-port wr/rd strobes) and the hardware access ports (curr_value, next_value, pulse).

Parameters:
F_WIDTH, 32, field width in bits (1..64)
RST_VALUE, 0, value loaded on fsm_rstn low or soft_rst high
SW_TYPE, 0, 0=RW, 1=RO (SW writes ignored), 2=WO (read data forced 0)
ONWRITE, 0, 0=NA(plain write), 1=WOCLR, 2=WOSET, 3=WOT, 4=WZS, 5=WZC, 6=WZT, 7=WCLR, 8=WSET
ONREAD, 0, 0=none, 1=RCLR, 2=RSET
WRITE_ONCE, 0, 1=only first accepted SW write after reset takes effect
NUM_SW, 2, number of software access ports (1..4)
HW_PRIO, 0, 0=SW wins on same-cycle conflict, 1=HW wins

Ports:
fsm_clk  in  1  clock
fsm_rstn  in  1  synchronous active-low reset
soft_rst  in  1  synchronous soft reset, active high
sw_wr_en  in  NUM_SW  per-port write strobe (field selected)
sw_rd_en  in  NUM_SW  per-port read strobe (field selected)
sw_wr_data  in  NUM_SW*F_WIDTH  per-port write data, port i at [i*F_WIDTH +: F_WIDTH]
sw_rd_data  out  F_WIDTH  read data of granted port
hw_pulse  in  1  HW update strobe
hw_next_value  in  F_WIDTH  HW update value
curr_value  out  F_WIDTH  registered field value
swmod  out  1  granted SW write modified field this cycle
swacc  out  1  granted SW read this cycle
sw_conflict  out  1  more than one port strobed this cycle
wo_locked  out  1  write-once lock state

Behaviour:
- Single clock domain. Every state change happens at the rising edge of fsm_clk. fsm_rstn and soft_rst are both synchronous.
- Reset values: fsm_rstn=0 gives curr_value=RST_VALUE and wo_locked=0. soft_rst=1 does the same and is next in priority after fsm_rstn.
- Arbitration (combinational): the lowest-index port with wr_en|rd_en is granted. Other ports are ignored that cycle. sw_conflict=1 when the popcount of (wr_en|rd_en) is greater than 1.
- On the granted port, wr_en=1 makes the access a write and any rd_en on that port is ignored. Otherwise the access is a read.
- Write result, with q=curr_value and d=granted data:
  - NA: d
  - WOCLR: q&~d
  - WOSET: q|d
  - WOT: q^d
  - WZS: q|~d
  - WZC: q&d
  - WZT: q^~d
  - WCLR: 0
  - WSET: all ones
- A write is effective unless SW_TYPE=RO, or WRITE_ONCE=1 and wo_locked=1.
- Effective write: curr_value takes the write result at the next edge. swmod=1 in the same cycle, even if the value is unchanged. With WRITE_ONCE=1, wo_locked goes to 1 at the same edge.
- Read: sw_rd_data is combinational and equals q, the pre-side-effect value (0 if SW_TYPE=WO). swacc=1. With ONREAD RCLR/RSET, curr_value becomes 0 or all ones at the next edge.
- When no port is granted: sw_rd_data=0, swmod=0, swacc=0.
- HW update: hw_pulse=1 makes curr_value take hw_next_value at the next edge.
- Same-cycle HW update and SW side effect (effective write or onread effect):
  - HW_PRIO=0: the SW result is taken and the HW update is dropped.
  - HW_PRIO=1: the HW value is taken. swmod/swacc still assert. wo_locked still sets.
- Ineffective writes (RO or locked) never block the HW update.
- Latency: write to curr_value is 1 cycle. Read data is available in the strobe cycle (0 cycles).
- Width rule: all operations are bitwise on F_WIDTH bits. There is no arithmetic and no truncation.

Test Plan:
- ONWRITE=1 (WOCLR), F_WIDTH=32, RST_VALUE=FFFF0000: write 0000FFFF leaves FFFF0000. Write FFFFFFFF gives 00000000. swmod pulses 1 cycle each write.
- ONWRITE=6 (WZT), RST_VALUE=0: write 00000000 gives FFFFFFFF. Write FFFFFFFF leaves FFFFFFFF. Write 0F0F0F0F gives 0F0F0F0F.
- ONREAD=1, RST_VALUE=A5A5A5A5:
  - First read returns A5A5A5A5 and curr_value is 0 next cycle.
  - Second read returns 0.
  - Read on the same cycle as hw_pulse with 12345678: HW_PRIO=0 gives 0; HW_PRIO=1 gives 12345678.
- NUM_SW=2: port1 write 11111111 and port0 write 22222222 in the same cycle give 22222222 and sw_conflict=1. Port1 alone then writes, giving 11111111.
- WRITE_ONCE=1: write 0000BEEF is taken and wo_locked=1. Write 0000DEAD is ignored (swmod=0) and the value stays 0000BEEF. soft_rst restores RST_VALUE and clears the lock, after which a write to 0000DEAD is taken.
- SW_TYPE=1 (RO): write FFFFFFFF gives no change and swmod=0. With hw_pulse=1 and hw_next_value=CAFEF00D in the same cycle as an SW write, curr_value is CAFEF00D. Drop fsm_rstn mid-sequence and curr_value is RST_VALUE at the next edge.
